// File: rtl/trap_mux_sequencer_pkg.sv
// trap_mux_sequencer_pkg: shared FSM state codes and valve vector type for the trap sequencer
package trap_mux_sequencer_pkg;
   typedef logic [2:0] state_t;
   localparam state_t S_IDLE    = 3'd0;
   localparam state_t S_LOAD    = 3'd1;
   localparam state_t S_FLUSH   = 3'd2;
   localparam state_t S_GAP     = 3'd3;
   localparam state_t S_RELEASE = 3'd4;
   localparam state_t S_DONE    = 3'd5;
   typedef struct packed {
      logic in_row;
      logic chain;
      logic k1;
      logic k2;
      logic m_chain;
   } air_t;
   localparam air_t AIR_CLOSED = air_t'(5'h1f);
endpackage

// File: rtl/trap_lane_pick.sv
// trap_lane_pick: combinational lowest-set-bit finder over the latched lane mask
module trap_lane_pick #(
   parameter int N_CH  = 8,
   parameter int IDX_W = 3
) (
   input  logic [N_CH-1:0]  mask,
   output logic [IDX_W-1:0] idx,
   output logic             found
);
   // scan from the top so the lowest set bit is the last to win
   always_comb begin
      idx   = '0;
      found = |mask;
      for (int i = N_CH - 1; i >= 0; i--)
         if (mask[i]) idx = IDX_W'(i);
   end
endmodule

// File: rtl/trap_mux_sequencer.sv
// trap_mux_sequencer: start/abort driven LOAD-FLUSH-RELEASE valve sequencer with registered outputs
module trap_mux_sequencer
   import trap_mux_sequencer_pkg::*;
#(
   parameter int N_CH      = 8,
   parameter int CNT_W     = 16,
   parameter int LOAD_CYC  = 100,
   parameter int FLUSH_CYC = 50,
   parameter int REL_CYC   = 80,
   localparam int IDX_W    = N_CH > 1 ? $clog2(N_CH) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   input  logic [N_CH-1:0]  ch_mask,
   output logic             busy,
   output logic             done,
   output logic [IDX_W-1:0] ch_idx,
   output logic             air_in_row,
   output logic             air_chain,
   output logic             air_k1,
   output logic             air_k2,
   output logic             air_m_chain,
   output logic [N_CH-1:0]  air_rel
);
   localparam logic [CNT_W-1:0] LOAD_END  = CNT_W'(LOAD_CYC - 1);
   localparam logic [CNT_W-1:0] FLUSH_END = CNT_W'(FLUSH_CYC - 1);
   localparam logic [CNT_W-1:0] REL_END   = CNT_W'(REL_CYC - 1);
   state_t state_q, state_d;
   logic [CNT_W-1:0] timer_q, timer_d;
   logic [N_CH-1:0] mask_q, mask_d, rel_q, rel_d;
   logic [IDX_W-1:0] lane_q, lane_d, idx_q, idx_d, pick_idx;
   logic pick_found, busy_q, busy_d, done_q, done_d;
   air_t air_q, air_d;
   trap_lane_pick #(.N_CH(N_CH), .IDX_W(IDX_W)) u_pick (
      .mask  (mask_q),
      .idx   (pick_idx),
      .found (pick_found)
   );
   // phase sequencing: timer restarts on every phase entry, abort overrides everything
   always_comb begin
      state_d = state_q;
      timer_d = timer_q + 1'b1;
      mask_d  = mask_q;
      lane_d  = lane_q;
      case (state_q)
         S_IDLE: begin
            timer_d = '0;
            if (start) begin
               state_d = S_LOAD;
               mask_d  = ch_mask;
            end
         end
         S_LOAD: if (timer_q == LOAD_END) begin
            state_d = S_FLUSH;
            timer_d = '0;
         end
         S_FLUSH: if (timer_q == FLUSH_END) begin
            state_d = S_GAP;
            timer_d = '0;
         end
         S_GAP: begin
            timer_d = '0;
            state_d = pick_found ? S_RELEASE : S_DONE;
            lane_d  = pick_idx;
         end
         S_RELEASE: if (timer_q == REL_END) begin
            state_d = S_GAP;
            timer_d = '0;
            mask_d  = mask_q & ~(N_CH'(1) << lane_q);
         end
         default: begin
            state_d = S_IDLE;
            timer_d = '0;
         end
      endcase
      if (abort && state_q != S_IDLE) begin
         state_d = S_IDLE;
         timer_d = '0;
      end
   end
   // outputs decoded from the next state so they register alongside it
   always_comb begin
      busy_d = state_d != S_IDLE;
      done_d = state_d == S_DONE;
      air_d  = '{state_d != S_LOAD, state_d != S_FLUSH, state_d != S_FLUSH,
                 state_d != S_RELEASE, state_d != S_RELEASE};
      rel_d  = state_d == S_RELEASE ? ~(N_CH'(1) << lane_d) : '1;
      idx_d  = state_d == S_RELEASE ? lane_d : '0;
   end
   // state and output registers, reset to the all-closed safe state
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         timer_q <= '0;
         mask_q  <= '0;
         lane_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         air_q   <= AIR_CLOSED;
         rel_q   <= '1;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         mask_q  <= mask_d;
         lane_q  <= lane_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         air_q   <= air_d;
         rel_q   <= rel_d;
         idx_q   <= idx_d;
      end
   end
   assign busy        = busy_q;
   assign done        = done_q;
   assign ch_idx      = idx_q;
   assign air_in_row  = air_q.in_row;
   assign air_chain   = air_q.chain;
   assign air_k1      = air_q.k1;
   assign air_k2      = air_q.k2;
   assign air_m_chain = air_q.m_chain;
   assign air_rel     = rel_q;
endmodule

// File: tb/tb_trap_mux_sequencer.sv
// tb_trap_mux_sequencer: cycle-exact scoreboard bench for the trap sequencer
module tb_trap_mux_sequencer;
   localparam int N_CH = 8;
   localparam int IDX_W = 3;
   localparam int LC = 4;
   localparam int FC = 3;
   localparam int RC = 2;
   localparam int VW = 2 + IDX_W + 5 + N_CH;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start = 1'b0;
   logic abort = 1'b0;
   logic [N_CH-1:0] ch_mask = '0;
   logic busy, done, air_in_row, air_chain, air_k1, air_k2, air_m_chain;
   logic [IDX_W-1:0] ch_idx;
   logic [N_CH-1:0] air_rel;
   int n_tests = 0;
   int n_fail = 0;
   logic [VW-1:0] sb[$];
   always #5 clk = ~clk;
   trap_mux_sequencer #(
      .N_CH(N_CH), .CNT_W(16), .LOAD_CYC(LC), .FLUSH_CYC(FC), .REL_CYC(RC)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .ch_mask(ch_mask),
      .busy(busy), .done(done), .ch_idx(ch_idx), .air_in_row(air_in_row),
      .air_chain(air_chain), .air_k1(air_k1), .air_k2(air_k2),
      .air_m_chain(air_m_chain), .air_rel(air_rel)
   );
   function automatic logic [VW-1:0] vec(input logic b, input logic d, input int idx,
                                         input logic [4:0] air, input int rel);
      logic [N_CH-1:0] r;
      r = (rel >= 0) ? ~(N_CH'(1) << rel) : '1;
      return {b, d, IDX_W'(idx), air, r};
   endfunction
   function automatic logic [VW-1:0] obs();
      return {busy, done, ch_idx, air_in_row, air_chain, air_k1, air_k2, air_m_chain, air_rel};
   endfunction
   // expected trace of one run, from the cycle after accept through the first idle cycle
   task automatic push_run(input logic [N_CH-1:0] m);
      repeat (LC) sb.push_back(vec(1, 0, 0, 5'b01111, -1));
      repeat (FC) sb.push_back(vec(1, 0, 0, 5'b10011, -1));
      for (int i = 0; i < N_CH; i++)
         if (m[i]) begin
            sb.push_back(vec(1, 0, 0, 5'b11111, -1));
            repeat (RC) sb.push_back(vec(1, 0, i, 5'b11100, i));
         end
      sb.push_back(vec(1, 0, 0, 5'b11111, -1));
      sb.push_back(vec(1, 1, 0, 5'b11111, -1));
      sb.push_back(vec(0, 0, 0, 5'b11111, -1));
   endtask
   task automatic test_reset();
      logic [VW-1:0] e;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         sb.push_back(vec(0, 0, 0, 5'b11111, -1));
         @(negedge clk);
         e = sb.pop_front();
         n_tests++;
         if (obs() !== e) begin
            n_fail++;
            $display("FAIL reset_idle cyc %0d: got %h want %h", i, obs(), e);
         end
      end
   endtask
   task automatic test_run(input logic [N_CH-1:0] m, input int exp_lat, input string name);
      logic [VW-1:0] e;
      int cyc, lat;
      @(negedge clk);
      start = 1'b1;
      ch_mask = m;
      push_run(m);
      cyc = -1;
      lat = -1;
      while (sb.size() > 0) begin
         @(negedge clk);
         start = 1'b0;
         cyc++;
         e = sb.pop_front();
         n_tests++;
         if (obs() !== e) begin
            n_fail++;
            $display("FAIL %s cyc %0d: got %h want %h", name, cyc, obs(), e);
         end
         if (done && lat < 0) lat = cyc;
      end
      n_tests++;
      if (lat !== exp_lat) begin
         n_fail++;
         $display("FAIL %s_done_latency: got %0d want %0d", name, lat, exp_lat);
      end
   endtask
   task automatic test_abort();
      logic [VW-1:0] e;
      int cyc;
      @(negedge clk);
      start = 1'b1;
      ch_mask = 8'b1000_0101;
      push_run(8'b1000_0101);
      cyc = -1;
      while (sb.size() > 0) begin
         @(negedge clk);
         start = 1'b0;
         abort = 1'b0;
         cyc++;
         e = sb.pop_front();
         n_tests++;
         if (obs() !== e) begin
            n_fail++;
            $display("FAIL abort cyc %0d: got %h want %h", cyc, obs(), e);
         end
         if (cyc == 12) begin
            abort = 1'b1;
            sb.delete();
            repeat (3) sb.push_back(vec(0, 0, 0, 5'b11111, -1));
         end
      end
      test_run(8'b1000_0101, 17, "after_abort");
   endtask
   task automatic test_ignore_inputs();
      logic [VW-1:0] e;
      int cyc, lat;
      @(negedge clk);
      start = 1'b1;
      ch_mask = 8'b0000_0110;
      push_run(8'b0000_0110);
      cyc = -1;
      lat = -1;
      while (sb.size() > 0) begin
         @(negedge clk);
         start = 1'b0;
         cyc++;
         e = sb.pop_front();
         n_tests++;
         if (obs() !== e) begin
            n_fail++;
            $display("FAIL ignore cyc %0d: got %h want %h", cyc, obs(), e);
         end
         if (done && lat < 0) lat = cyc;
         if (cyc == 5) begin
            start = 1'b1;
            ch_mask = 8'hff;
         end
         if (cyc == 9) ch_mask = 8'h01;
      end
      n_tests++;
      if (lat !== 14) begin
         n_fail++;
         $display("FAIL ignore_done_latency: got %0d want 14", lat);
      end
   endtask
   task automatic test_rst_mid_run();
      logic [VW-1:0] e;
      int cyc;
      @(negedge clk);
      start = 1'b1;
      ch_mask = 8'h81;
      push_run(8'h81);
      cyc = -1;
      while (sb.size() > 0) begin
         @(negedge clk);
         start = 1'b0;
         rst = 1'b0;
         cyc++;
         e = sb.pop_front();
         n_tests++;
         if (obs() !== e) begin
            n_fail++;
            $display("FAIL rst_mid_run cyc %0d: got %h want %h", cyc, obs(), e);
         end
         if (cyc == 1) begin
            rst = 1'b1;
            sb.delete();
            sb.push_back(vec(0, 0, 0, 5'b11111, -1));
         end else if (cyc == 2) begin
            start = 1'b1;
            ch_mask = 8'h18;
            push_run(8'h18);
         end
      end
   endtask
   initial begin
      test_reset();
      test_run(8'b1000_0101, 17, "release_order");
      test_run(8'h00, 8, "zero_mask");
      test_abort();
      test_ignore_inputs();
      test_rst_mid_run();
      test_run(8'h80, 11, "top_lane");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/trap_mux_sequencer.md
# trap_mux_sequencer

Clocked pneumatic sequencer for the next-generation cell-trap multiplexer: N_CH parallel trap lanes, each with an inlet valve, a shared chain line, per-lane trap and per-lane release valves, and a flush pair k1/k2 feeding a mixer tree. It replaces hand-driven control lines with a start/abort-controlled run of timed phases. Per-lane release valves are individually addressable, and lanes can be selected by mask. It sits between the host control interface and the pneumatic air_in nets of the valve array.

## Interface
Parameters:
- N_CH, 8: number of trap lanes (≥1).
- CNT_W, 16: phase-timer width.
- LOAD_CYC, 100: cycles inlet valves stay open in LOAD (1..2^CNT_W-1).
- FLUSH_CYC, 50: cycles of the k1 flush through the lane chain.
- REL_CYC, 80: cycles each selected lane is released toward the tree.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  run request; sampled only in IDLE.
- abort  in  1  terminate run; wins over every other input.
- ch_mask  in  N_CH  lanes to release; captured on an accepted start.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse on normal completion.
- ch_idx  out  $clog2(N_CH) (min 1)  lane currently in RELEASE, else 0.
- air_in_row  out  1  inlet valves (c1).
- air_chain  out  1  lane chain valves (c2).
- air_k1  out  1  flush-in valve (c3).
- air_k2  out  1  flush-out valve (c4).
- air_m_chain  out  1  trap-side chain (c5).
- air_rel  out  N_CH  per-lane release valves (replaces shared c6).

## Operation
- Valve polarity: air output 1 = pressurised = valve closed; 0 = open. Safe state is all air outputs 1.
- The outputs are registered. Reset state: every air output is 1, busy=0, done=0, ch_idx=0, the FSM is in IDLE, and the timer is 0.
- States and their open valves:
  - IDLE: all valves closed.
  - LOAD: air_in_row=0.
  - FLUSH: air_chain=0, air_k1=0.
  - RELEASE: air_k2=0, air_m_chain=0, air_rel[ch_idx]=0.
  - GAP: all valves closed, for exactly 1 cycle.
  - DONE: all valves closed, done=1, for exactly 1 cycle.
- State transitions:
  - IDLE to LOAD on start=1. The mask is latched on the same cycle.
  - LOAD to FLUSH after LOAD_CYC cycles.
  - FLUSH to GAP after FLUSH_CYC cycles.
  - GAP to RELEASE of the lowest remaining masked lane. If no masked lane remains, GAP goes to DONE.
  - RELEASE to GAP after REL_CYC cycles. The released lane is cleared from the latched mask.
  - DONE to IDLE.
- Break-before-make: GAP separates every pair of open-valve phases except LOAD to FLUSH. On LOAD to FLUSH, air_in_row closes on the same edge air_chain opens.
- abort=1 in any non-IDLE state: next state is IDLE with all valves closed and no done pulse. abort in IDLE has no effect.
- start during busy is ignored and is not queued.
- Changes to ch_mask after start are ignored.
- An all-zero mask runs LOAD, FLUSH, GAP, DONE.
- Timer: it loads 0 on entry to each timed phase and increments each cycle. The phase exits when timer == PHASE_CYC-1, so each phase lasts exactly PHASE_CYC cycles. There is no wrap, because the parameters are bounded below 2^CNT_W.

## Timing
- start sampled at edge t: busy=1 and air_in_row=0 are visible from t+1.
- Total run length from accept to done, for m selected lanes: LOAD_CYC + FLUSH_CYC + 1 + m·(REL_CYC+1) cycles. done is high on the final cycle, and busy falls on the cycle after done.
- ch_idx is valid on the same cycles air_rel[ch_idx]=0.
- At most one bit of air_rel is 0 on any cycle.
- rst asserted mid-run: the next cycle shows the full reset state.

## Structure
- A shared package holds the FSM state enum (IDLE, LOAD, FLUSH, GAP, RELEASE, DONE) and the all-closed air-vector constant.
- The single sub-module is trap_lane_pick: a combinational lowest-set-bit finder over the latched mask. It returns the index and a found flag.
- The top level holds the FSM, the timer, the latched mask, and the output registers.

## Test plan
- Reset, then idle 10 cycles: all air outputs 1, busy=0, done=0.
- N_CH=8, LOAD/FLUSH/REL = 4/3/2, mask=8'b1000_0101, start: air_rel[0], [2], [7] open for 2 cycles each, in that order. Each release is preceded by a 1-cycle all-closed GAP. done arrives 4+3+1+3·3=17 cycles after accept.
- mask=0: done 4+3+1=8 cycles after accept; air_rel stays all 1.
- abort on the 2nd RELEASE cycle of lane 2: next cycle all closed, busy=0, no done pulse. A subsequent start runs the full sequence normally.
- start pulsed again during FLUSH, and ch_mask changed mid-run: no effect on sequence or timing.
- rst during LOAD: reset state on the next cycle. A start on the cycle after rst deasserts is accepted.
